// File: rtl/prio_grant_dispatcher_pkg.sv
// Shared definitions for the grant dispatcher: FSM state encoding and
// the timeout counter width helper.
package prio_grant_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Counter must reach TIMEOUT-1 without wrapping; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/prio_grant_dispatcher_index_decoder.sv
// Combinational index -> one-hot decode with a range flag; the caller
// registers the result.
module prio_grant_dispatcher_index_decoder #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0] index,
  output logic [N-1:0]     onehot_c,
  output logic             in_range_c
);

  for (genvar i = 0; i < N; i++) begin : g_dec
    assign onehot_c[i] = (32'(index) == i);
  end

  // Only meaningful when N < 2**IDX_W; otherwise always true.
  assign in_range_c = (32'(index) < N);

endmodule

// File: rtl/prio_grant_dispatcher.sv
// Consumer of the priority-encoder result: holds a one-hot grant until the
// owner's done bit or a timeout, freezing the encoder while a grant is live.
module prio_grant_dispatcher
  import prio_grant_dispatcher_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] enc_index,
  input  logic             enc_valid,
  output logic             enc_enable_n,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_index,
  output logic             grant_valid,
  input  logic [N-1:0]     done,
  output logic             timeout,
  output logic             err_index
);

  localparam int unsigned   CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [N-1:0]     grant_d;
  logic [IDX_W-1:0] grant_index_d;
  logic             grant_valid_d;
  logic             timeout_d;
  logic             err_index_d;
  logic [N-1:0]     onehot_c;
  logic             in_range_c;
  logic             owner_done_c;

  prio_grant_dispatcher_index_decoder #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_dec (
    .index      (enc_index),
    .onehot_c   (onehot_c),
    .in_range_c (in_range_c)
  );

  // grant is one-hot on grant_index while in GRANT, so this selects done[grant_index].
  assign owner_done_c = |(done & grant);
  assign enc_enable_n = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RELEASE;
      count       <= '0;
      grant       <= '0;
      grant_index <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      err_index   <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      grant       <= grant_d;
      grant_index <= grant_index_d;
      grant_valid <= grant_valid_d;
      timeout     <= timeout_d;
      err_index   <= err_index_d;
    end
  end

  always_comb begin
    state_d       = state;
    count_d       = count;
    grant_d       = grant;
    grant_index_d = grant_index;
    grant_valid_d = grant_valid;
    timeout_d     = 1'b0;
    err_index_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enc_valid) begin
          if (in_range_c) begin
            grant_d       = onehot_c;
            grant_index_d = enc_index;
            grant_valid_d = 1'b1;
            count_d       = '0;
            state_d       = ST_GRANT;
          end else begin
            err_index_d = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        // done takes precedence over a coincident terminal count
        if (owner_done_c) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          state_d       = ST_RELEASE;
        end else if ((TIMEOUT != 0) && (count == TERM)) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          timeout_d     = 1'b1;
          state_d       = ST_RELEASE;
        end else if (TIMEOUT != 0) begin
          count_d = count + CNT_W'(1);
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_RELEASE;
    endcase
  end

endmodule

// File: tb/tb_prio_grant_dispatcher.sv
// Bench for prio_grant_dispatcher: a 16-way and a 12-way instance fed by a
// modelled priority encoder, checked every cycle against a behavioural model.
module tb_prio_grant_dispatcher;

  localparam int TO = 8;
  localparam int P_IDLE = 0, P_GRANT = 1, P_REL = 2;

  typedef struct packed {
    int          ph;
    int          idx;
    int          cnt;
    logic [15:0] grant;
    logic        to;
    logic        err;
  } model_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data, done;
  logic [3:0]  enc_index;
  logic        enc_valid;

  logic        a_en_n, a_gv, a_to, a_err;
  logic [15:0] a_grant;
  logic [3:0]  a_idx;
  logic        b_en_n, b_gv, b_to, b_err;
  logic [11:0] b_grant;
  logic [3:0]  b_idx;

  int n_vec = 0, n_err = 0;
  bit chk_en = 0;
  model_t m[2];

  always #5 clk = ~clk;

  // Highest set bit wins, as in PriorityEncoder16.
  always_comb begin
    enc_valid = |data;
    enc_index = '0;
    for (int i = 0; i < 16; i++) if (data[i]) enc_index = 4'(i);
  end

  prio_grant_dispatcher #(.N(16), .IDX_W(4), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(reset), .enc_index(enc_index), .enc_valid(enc_valid),
    .enc_enable_n(a_en_n), .grant(a_grant), .grant_index(a_idx), .grant_valid(a_gv),
    .done(done), .timeout(a_to), .err_index(a_err));

  prio_grant_dispatcher #(.N(12), .IDX_W(4), .TIMEOUT(TO)) dut_b (
    .clk(clk), .reset(reset), .enc_index(enc_index), .enc_valid(enc_valid),
    .enc_enable_n(b_en_n), .grant(b_grant), .grant_index(b_idx), .grant_valid(b_gv),
    .done(done[11:0]), .timeout(b_to), .err_index(b_err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t r;
    r.ph = P_REL; r.idx = 0; r.cnt = 0; r.grant = '0; r.to = 1'b0; r.err = 1'b0;
    return r;
  endfunction

  function automatic model_t step(model_t s, int n, logic v, int idx, logic [15:0] dn);
    model_t r = s;
    r.to = 1'b0;
    r.err = 1'b0;
    if (s.ph == P_IDLE) begin
      if (v && idx < n) begin
        r.ph = P_GRANT; r.idx = idx; r.cnt = 0; r.grant = 16'(1) << idx;
      end else if (v) begin
        r.err = 1'b1;
      end
    end else if (s.ph == P_GRANT) begin
      if (dn[s.idx]) begin
        r.ph = P_REL; r.grant = '0;
      end else if (s.cnt == TO - 1) begin
        r.ph = P_REL; r.grant = '0; r.to = 1'b1;
      end else begin
        r.cnt = s.cnt + 1;
      end
    end else begin
      r.ph = P_IDLE;
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) m[k] <= model_reset();
    end else begin
      m[0] <= step(m[0], 16, enc_valid, int'(enc_index), done);
      m[1] <= step(m[1], 12, enc_valid, int'(enc_index), done);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a.grant",   32'(a_grant), 32'(m[0].grant));
      check("a.index",   32'(a_idx),   32'(m[0].idx));
      check("a.valid",   32'(a_gv),    32'(m[0].grant != 0));
      check("a.en_n",    32'(a_en_n),  32'(m[0].ph != P_IDLE));
      check("a.timeout", 32'(a_to),    32'(m[0].to));
      check("a.err",     32'(a_err),   32'(m[0].err));
      check("b.grant",   32'(b_grant), 32'(m[1].grant));
      check("b.index",   32'(b_idx),   32'(m[1].idx));
      check("b.valid",   32'(b_gv),    32'(m[1].grant != 0));
      check("b.en_n",    32'(b_en_n),  32'(m[1].ph != P_IDLE));
      check("b.timeout", 32'(b_to),    32'(m[1].to));
      check("b.err",     32'(b_err),   32'(m[1].err));
    end
  end

  task automatic go_idle();
    int n = 0;
    data = '0;
    done = 16'hFFFF;
    @(negedge clk);
    while ((a_en_n || b_en_n) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("idle_reached", 32'(a_en_n | b_en_n), 32'd0);
    done = '0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    data  = '0;
    done  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.grant", 32'(a_grant), 32'd0);
    check("rst.en_n",  32'(a_en_n),  32'd1);
    check("rst.valid", 32'(a_gv),    32'd0);
    #2 reset = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("post_rst.en_n", 32'(a_en_n), 32'd0);

    // single grant to 5, released by its own done
    data = 16'h0020;
    @(negedge clk);
    check("g5.grant", 32'(a_grant), 32'h0020);
    check("g5.index", 32'(a_idx),   32'd5);
    check("g5.en_n",  32'(a_en_n),  32'd1);
    data = '0;
    done = 16'h0020;
    @(negedge clk);
    done = '0;
    check("g5.rel_grant", 32'(a_grant), 32'd0);
    check("g5.rel_en_n",  32'(a_en_n),  32'd1);
    @(negedge clk);
    check("g5.idle_en_n", 32'(a_en_n), 32'd0);

    // 0xEF: only done[7] releases; re-grant after a 2-cycle gap
    data = 16'h00EF;
    @(negedge clk);
    check("g7.grant", 32'(a_grant), 32'h0080);
    done = 16'h0008;
    @(negedge clk);
    check("g7.noise_held", 32'(a_grant), 32'h0080);
    done = '0;
    @(negedge clk);
    done = 16'h0080;
    @(negedge clk);
    done = '0;
    check("g7.gap1", 32'(a_grant), 32'd0);
    @(negedge clk);
    check("g7.gap2", 32'(a_grant), 32'd0);
    @(negedge clk);
    check("g7.regrant", 32'(a_grant), 32'h0080);
    go_idle();

    // timeout: grant held exactly TO cycles
    data = 16'h0010;
    @(negedge clk);
    data = '0;
    cnt = 0;
    while (a_gv && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("to.held_cycles", 32'(cnt),   32'd8);
    check("to.pulse",       32'(a_to),  32'd1);
    check("to.index_kept",  32'(a_idx), 32'd4);
    @(negedge clk);
    check("to.pulse_end", 32'(a_to), 32'd0);
    go_idle();

    // done coincident with terminal count: no timeout pulse
    data = 16'h0010;
    @(negedge clk);
    data = '0;
    repeat (7) @(negedge clk);
    check("coinc.held", 32'(a_grant), 32'h0010);
    done = 16'h0010;
    @(negedge clk);
    done = '0;
    check("coinc.grant", 32'(a_grant), 32'd0);
    check("coinc.to",    32'(a_to),    32'd0);
    go_idle();

    // reset in the third grant cycle
    data = 16'h0080;
    @(negedge clk);
    data = '0;
    repeat (2) @(negedge clk);
    check("rg.held", 32'(a_grant), 32'h0080);
    #2 reset = 1'b1;
    #1;
    check("rg.grant", 32'(a_grant), 32'd0);
    check("rg.en_n",  32'(a_en_n),  32'd1);
    check("rg.pulse", 32'({a_to, a_err}), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    go_idle();

    // index 13 is out of range for the 12-way instance
    data = 16'h2000;
    @(negedge clk);
    check("n12.err",   32'(b_err),   32'd1);
    check("n12.grant", 32'(b_grant), 32'd0);
    check("n12.en_n",  32'(b_en_n),  32'd0);
    check("n16.index", 32'(a_idx),   32'd13);
    data = '0;
    @(negedge clk);
    check("n12.err_end", 32'(b_err), 32'd0);
    go_idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      data = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'($urandom) & 16'($urandom));
      done = ($urandom_range(0, 4) == 0) ? (16'(1) << $urandom_range(0, 15)) : 16'h0;
      if ($urandom_range(0, 7) == 0) done = done | 16'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    go_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
